// File: rtl/mac_issue_if.sv
// Handshake and status bundle between the MAC issue scheduler and its
// operand-read, datapath and write-back neighbours.
interface mac_issue_if #(
  parameter int LATENCY   = 4,
  parameter int DATA_W    = 32,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 8
);
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [LATENCY-1:0]           stage_en;
  logic [DATA_W-1:0]            mac_result;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_data;
  logic [TAG_W-1:0]             out_tag;
  logic [$clog2(RES_DEPTH):0]   credits;
  logic                         busy;

  // master: the scheduler itself
  modport master (
    input  flush, in_valid, mac_result, out_ready,
    output in_ready, stage_en, out_valid, out_data, out_tag, credits, busy
  );

  // slave: the surrounding read / datapath / write-back logic
  modport slave (
    output flush, in_valid, mac_result, out_ready,
    input  in_ready, stage_en, out_valid, out_data, out_tag, credits, busy
  );
endinterface

// File: rtl/mac_issue_scheduler.sv
// Credit-based issue scheduler for the MAC pipeline: token pipe drives the
// per-stage enables, finished results land in an in-order tagged FIFO.
module mac_issue_scheduler #(
  parameter int LATENCY   = 4,
  parameter int DATA_W    = 32,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  mac_issue_if.master bus
);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int PW = $clog2(RES_DEPTH);
  localparam int EW = DATA_W + TAG_W;

  logic               issue;
  logic               push;
  logic               pop;
  logic               fifoNonEmpty;
  logic [LATENCY-1:0] tok;
  logic [LATENCY-1:0] stageEn;
  logic [TAG_W-1:0]   tagPipe [LATENCY];
  logic [TAG_W-1:0]   issueTag;
  logic [EW-1:0]      fifoMem [RES_DEPTH];
  logic [EW-1:0]      headWord;
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;
  logic [CW-1:0]      fifoCount;
  logic [CW-1:0]      creditCount;

  assign bus.in_ready = (creditCount != '0) && !bus.flush;
  assign issue        = bus.in_valid && bus.in_ready;
  // A flush discards whatever the last stage is holding this cycle.
  assign push         = tok[LATENCY-1] && !bus.flush;
  assign fifoNonEmpty = (fifoCount != '0);
  assign pop          = fifoNonEmpty && bus.out_ready && !bus.flush;

  // Stage 0 fires on admission; later stages follow the token one cycle behind.
  assign stageEn[0] = issue;
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage_en
      assign stageEn[gi] = tok[gi-1] && !bus.flush;
    end
  endgenerate
  assign bus.stage_en = stageEn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok      <= '0;
      issueTag <= '0;
    end else if (bus.flush) begin
      tok      <= '0;
      issueTag <= '0;
    end else begin
      tok <= {tok[LATENCY-2:0], issue};
      if (issue) begin
        issueTag <= issueTag + 1'b1;
      end
    end
  end

  // Tags ride alongside their tokens; stale tags behind a cleared token are harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tagPipe[0] <= '0;
    end else begin
      tagPipe[0] <= issueTag;
    end
  end

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag_pipe
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tagPipe[gi] <= '0;
        end else begin
          tagPipe[gi] <= tagPipe[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= {tagPipe[LATENCY-1], bus.mac_result};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      creditCount <= CW'(RES_DEPTH);
    end else if (bus.flush) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      creditCount <= CW'(RES_DEPTH);
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
      case ({issue, pop})
        2'b10:   creditCount <= creditCount - 1'b1;
        2'b01:   creditCount <= creditCount + 1'b1;
        default: creditCount <= creditCount;
      endcase
    end
  end

  // First-word-fall-through head, held at zero while empty.
  assign headWord      = fifoMem[rdPtr];
  assign bus.out_valid = fifoNonEmpty;
  assign bus.out_data  = fifoNonEmpty ? headWord[DATA_W-1:0] : '0;
  assign bus.out_tag   = fifoNonEmpty ? headWord[EW-1:DATA_W] : '0;
  assign bus.credits   = creditCount;
  assign bus.busy      = (|tok) || fifoNonEmpty;

  // Credits bound the occupancy, so a capture into a full FIFO means the credit loop broke.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (reset)
    !(push && !pop && (fifoCount == CW'(RES_DEPTH)))
  );
endmodule
